// File: rtl/prm_mask_pkg.sv
// Shared definitions for the PRM obstacle-mask sequencer: code width,
// sequencer states and the default bitmap word type.
package prm_mask_pkg;

  localparam int CODE_W     = 15;
  localparam int WORD_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  typedef logic [WORD_W_DEF-1:0] word_t;

endpackage

// File: rtl/prm_popcount.sv
// Population count of one bitmap word. Only built with PRM_MASK_CNT_EN,
// the macro that enables the blocked-edge counter in prm_obstacle_mask_accum.
`ifdef PRM_MASK_CNT_EN
module prm_popcount
  import prm_mask_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  localparam int POP_W = $clog2(WORD_W + 1)
) (
  input  logic [WORD_W-1:0] data_i,
  output logic [POP_W-1:0]  count_o
);

  // Sum of set bits across the word.
  always_comb begin
    logic [POP_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < WORD_W; i++) begin
      acc = acc + POP_W'(data_i[i]);
    end
    count_o = acc;
  end

endmodule
`endif

// File: rtl/prm_obstacle_mask_accum.sv
// PRM obstacle-mask sequencer: broadcasts each obstacle code to the checker
// bank, ORs the returned edge masks into a sticky bitmap, then streams the
// bitmap out word by word.
// Optional feature macro: PRM_MASK_CNT_EN adds the blocked_cnt output.
module prm_obstacle_mask_accum
  import prm_mask_pkg::*;
#(
  parameter int NUM_EDGES = 1024,
  parameter int WORD_W    = 32,
  localparam int NW       = NUM_EDGES / WORD_W,
  localparam int IW       = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 obs_valid,
  output logic                 obs_ready,
  input  logic [CODE_W-1:0]    obs_code,
  input  logic                 obs_last,
  output logic [CODE_W-1:0]    chk_code,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic                 mask_valid,
  input  logic                 mask_ready,
  output logic [WORD_W-1:0]    mask_data,
  output logic [IW-1:0]        mask_widx,
  output logic                 mask_last,
  output logic                 busy
`ifdef PRM_MASK_CNT_EN
  ,
  output logic [$clog2(NUM_EDGES+1)-1:0] blocked_cnt
`endif
);

  localparam logic [IW-1:0] LAST_WIDX = IW'(NW - 1);

  state_e               state_q, state_d;
  logic                 pend_q, pend_d;
  logic [CODE_W-1:0]    chk_code_q, chk_code_d;
  logic [NUM_EDGES-1:0] bitmap_q, bitmap_d;
  logic [IW-1:0]        widx_q, widx_d;
  logic                 obs_hs, mask_hs, word_last, start_acc;

  // Handshakes and outputs derive directly from registered state, so every
  // output falls to zero the moment reset asserts.
  assign obs_ready  = (state_q == ST_ACCUM);
  assign obs_hs     = obs_ready && obs_valid;
  assign mask_valid = (state_q == ST_OUT);
  assign mask_hs    = mask_valid && mask_ready;
  assign word_last  = (widx_q == LAST_WIDX);
  assign mask_last  = mask_valid && word_last;
  assign mask_data  = mask_valid ? bitmap_q[int'(widx_q)*WORD_W +: WORD_W] : '0;
  assign mask_widx  = widx_q;
  assign chk_code   = chk_code_q;
  assign busy       = (state_q != ST_IDLE);
  assign start_acc  = (state_q == ST_IDLE) && start;

  // Next-state logic: sequencing, code broadcast, mask merge one cycle later.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    pend_d     = 1'b0;
    chk_code_d = chk_code_q;
    bitmap_d   = bitmap_q;
    widx_d     = widx_q;
    // The checker answer for the code broadcast last cycle arrives now.
    if (pend_q) bitmap_d = bitmap_q | chk_mask;
    case (state_q)
      ST_IDLE: begin
        widx_d = '0;
        if (start) begin
          state_d  = ST_ACCUM;
          bitmap_d = '0;
        end
      end
      ST_ACCUM: begin
        if (obs_hs) begin
          chk_code_d = obs_code;
          pend_d     = 1'b1;
          if (obs_last) state_d = ST_DRAIN;
        end
      end
      // One cycle to fold in the mask of the final code.
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT: begin
        if (mask_hs) begin
          if (word_last) begin
            state_d = ST_IDLE;
            widx_d  = '0;
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; a reset mid-scan discards the partial bitmap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      chk_code_q <= '0;
      // NOTE: the bitmap is plain flops, not a RAM, so it can take the async
      // reset and guarantees no residue from an aborted scan.
      bitmap_q   <= '0;
      widx_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values.
      state_q    <= state_d;
      pend_q     <= pend_d;
      chk_code_q <= chk_code_d;
      bitmap_q   <= bitmap_d;
      widx_q     <= widx_d;
    end
  end

`ifdef PRM_MASK_CNT_EN
  localparam int CNT_W = $clog2(NUM_EDGES + 1);
  localparam int POP_W = $clog2(WORD_W + 1);

  logic [POP_W-1:0] word_pop;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  prm_popcount #(.WORD_W(WORD_W)) u_popcount (
    .data_i  (mask_data),
    .count_o (word_pop)
  );

  // Running count of blocked edges over the words handed downstream.
  always_comb begin
    cnt_d = cnt_q;
    if (start_acc)    cnt_d = '0;
    else if (mask_hs) cnt_d = cnt_q + CNT_W'(word_pop);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign blocked_cnt = cnt_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule
